// File: rtl/count4_disp2.sv
// count4_disp2: two-digit multiplexed 7-segment display for a 0..15 count.
// Value is latched once per frame so neither digit ever shows a torn value.
module count4_disp2 #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       upd
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    logic [DW-1:0] div_q;
    logic          sel_q;
    logic [3:0]    cnt_q;
    logic [3:0]    disp_q;

    logic          div_wrap;
    logic          frame_end;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    code;

    always_comb begin
        div_wrap  = (div_q == DIV_LAST);
        frame_end = div_wrap & sel_q;
    end

    // tens digit can only ever be "1" or blank for a 4-bit value
    always_comb begin
        digit = 4'd0;
        blank = 1'b0;
        unique case (1'b1)
            sel_q: begin
                digit = 4'd1;
                blank = (disp_q < 4'd10);
            end
            !sel_q: begin
                digit = (disp_q >= 4'd10) ? disp_q - 4'd10 : disp_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        code = 7'h00;
        case (digit)
            4'd0:    code = 7'h7E;
            4'd1:    code = 7'h30;
            4'd2:    code = 7'h6D;
            4'd3:    code = 7'h79;
            4'd4:    code = 7'h33;
            4'd5:    code = 7'h5B;
            4'd6:    code = 7'h5F;
            4'd7:    code = 7'h70;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h7B;
            default: code = 7'h00;
        endcase
        if (blank) begin
            code = 7'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= '0;
            sel_q  <= 1'b0;
            cnt_q  <= 4'd0;
            disp_q <= 4'd0;
            upd    <= 1'b0;
            an     <= 2'b00;
            seg    <= 7'h00;
        end else begin
            cnt_q <= count;
            if (div_wrap) begin
                div_q <= '0;
                sel_q <= ~sel_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (frame_end) begin
                disp_q <= cnt_q;
            end
            upd <= frame_end && (cnt_q != disp_q);
            // timing keeps running while blanked; only the drive is gated
            an  <= en ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
            seg <= en ? code : 7'h00;
        end
    end

endmodule

// File: tb/tb_count4_disp2.sv
// tb_count4_disp2: randomized and directed bench for count4_disp2.
// Reference model indexes time since reset rather than mimicking counters.
module tb_count4_disp2;

    localparam int R = 4;

    logic       clk;
    logic       rst;
    logic [3:0] count;
    logic       en;
    logic [6:0] seg;
    logic [1:0] an;
    logic       upd;

    count4_disp2 #(.REFRESH_DIV(R)) dut (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .en    (en),
        .seg   (seg),
        .an    (an),
        .upd   (upd)
    );

    always #5 clk = ~clk;

    logic [6:0] segtab [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    int         n_chk;
    int         n_fail;
    int         t;
    int         m_cnt;
    int         m_disp;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_upd;

    // one clock edge plus the model's view of what that edge produces
    task automatic tick();
        bit sel;
        bit bnd;
        @(posedge clk);
        if (!rst) begin
            t      = 0;
            m_cnt  = 0;
            m_disp = 0;
            e_seg  = 7'h00;
            e_an   = 2'b00;
            e_upd  = 1'b0;
        end else begin
            sel   = ((t / R) % 2) == 1;
            bnd   = (t % (2 * R)) == (2 * R - 1);
            e_an  = !en ? 2'b00 : (sel ? 2'b10 : 2'b01);
            if (!en)
                e_seg = 7'h00;
            else if (sel)
                e_seg = (m_disp >= 10) ? segtab[1] : 7'h00;
            else
                e_seg = segtab[m_disp % 10];
            e_upd = bnd && (m_cnt != m_disp);
            if (bnd)
                m_disp = m_cnt;
            m_cnt = count;
            t++;
        end
        #1;
    endtask

    task automatic test_reset();
        int ups;
        rst = 0;
        count = 4'd5;
        en = 1;
        repeat (3) begin
            tick();
            n_chk++;
            if ({seg, an, upd} !== {7'h00, 2'b00, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold seg=%h an=%b upd=%b want 00/00/0",
                         seg, an, upd);
            end
        end
        rst = 1;
        ups = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            ups += upd;
            n_chk++;
            if ({seg, an, upd} !== {e_seg, e_an, e_upd}) begin
                n_fail++;
                $display("FAIL reset_model t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg, an, upd, e_seg, e_an, e_upd);
            end
            if (i == 0 || i == 4 || i == 8) begin
                n_chk++;
                if ((i == 0 && {an, seg} !== {2'b01, 7'h7E}) ||
                    (i == 4 && {an, seg} !== {2'b10, 7'h00}) ||
                    (i == 8 && {an, seg} !== {2'b01, 7'h5B})) begin
                    n_fail++;
                    $display("FAIL reset_seq i=%0d an=%b seg=%h", i, an, seg);
                end
            end
        end
        n_chk++;
        if (ups != 1) begin
            n_fail++;
            $display("FAIL reset_upd got %0d pulses want 1", ups);
        end
    endtask

    task automatic test_hold13();
        int ups;
        rst = 0;
        count = 4'd13;
        tick();
        rst = 1;
        ups = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            ups += upd;
            n_chk++;
            if ({seg, an, upd} !== {e_seg, e_an, e_upd}) begin
                n_fail++;
                $display("FAIL hold13_model t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg, an, upd, e_seg, e_an, e_upd);
            end
            if (i >= 8 && i < 16) begin
                n_chk++;
                if ((i < 12 && {an, seg} !== {2'b01, 7'h79}) ||
                    (i >= 12 && {an, seg} !== {2'b10, 7'h30})) begin
                    n_fail++;
                    $display("FAIL hold13_phase i=%0d an=%b seg=%h", i, an, seg);
                end
            end
        end
        n_chk++;
        if (ups != 1) begin
            n_fail++;
            $display("FAIL hold13_upd got %0d pulses want 1", ups);
        end
    endtask

    task automatic test_no_tear();
        int ups;
        rst = 0;
        count = 4'd7;
        tick();
        rst = 1;
        ups = 0;
        for (int i = 0; i < 48; i++) begin
            if (i == 9)  count = 4'd8;
            if (i == 16) count = 4'd3;
            if (i == 34) count = 4'd4;
            if (i == 36) count = 4'd3;
            tick();
            if (i >= 32) ups += upd;
            n_chk++;
            if ({seg, an, upd} !== {e_seg, e_an, e_upd}) begin
                n_fail++;
                $display("FAIL tear_model t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg, an, upd, e_seg, e_an, e_upd);
            end
            if ((i >= 9 && i < 12) || i == 16 || i == 40) begin
                n_chk++;
                if ((i < 12 && seg !== 7'h70) ||
                    (i == 16 && seg !== 7'h7F) ||
                    (i == 40 && seg !== 7'h79)) begin
                    n_fail++;
                    $display("FAIL tear_seg i=%0d seg=%h", i, seg);
                end
            end
        end
        n_chk++;
        if (ups != 0) begin
            n_fail++;
            $display("FAIL tear_glitch_upd got %0d pulses want 0", ups);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vals  [0:2] = '{4'd14, 4'd15, 4'd0};
        logic [6:0] units [0:2] = '{7'h33, 7'h5B, 7'h7E};
        logic [6:0] tens  [0:2] = '{7'h30, 7'h30, 7'h00};
        for (int k = 0; k < 3; k++) begin
            count = vals[k];
            do begin
                tick();
                n_chk++;
                if ({seg, an, upd} !== {e_seg, e_an, e_upd}) begin
                    n_fail++;
                    $display("FAIL wrap_model t=%0d got %h/%b/%b want %h/%b/%b",
                             t, seg, an, upd, e_seg, e_an, e_upd);
                end
            end while (t % (2 * R) != 0);
            n_chk++;
            if (upd !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_upd k=%0d upd=%b want 1", k, upd);
            end
            tick();
            n_chk++;
            if (seg !== units[k]) begin
                n_fail++;
                $display("FAIL wrap_units k=%0d seg=%h want %h", k, seg, units[k]);
            end
            repeat (4) tick();
            n_chk++;
            if ({an, seg} !== {2'b10, tens[k]}) begin
                n_fail++;
                $display("FAIL wrap_tens k=%0d an=%b seg=%h want 10/%h",
                         k, an, seg, tens[k]);
            end
        end
    endtask

    task automatic test_enable();
        count = 4'd9;
        for (int i = 0; i < 24; i++) begin
            en = !(i >= 3 && i < 9);
            tick();
            n_chk++;
            if ({seg, an, upd} !== {e_seg, e_an, e_upd}) begin
                n_fail++;
                $display("FAIL en_model t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg, an, upd, e_seg, e_an, e_upd);
            end
            if (!en) begin
                n_chk++;
                if ({an, seg} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL en_blank i=%0d an=%b seg=%h", i, an, seg);
                end
            end
        end
        en = 1;
    endtask

    task automatic test_reset_mid();
        count = 4'd12;
        for (int f = 0; f < 2; f++) begin
            do tick(); while (t % (2 * R) != 0);
        end
        tick();
        n_chk++;
        if ({an, seg} !== {2'b01, 7'h6D}) begin
            n_fail++;
            $display("FAIL mid_pre an=%b seg=%h want 01/6d", an, seg);
        end
        while (t % (2 * R) != R + 1) tick();
        rst = 0;
        tick();
        n_chk++;
        if ({seg, an, upd} !== 10'd0 || dut.disp_q !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset seg=%h an=%b upd=%b disp=%0d want all 0",
                     seg, an, upd, dut.disp_q);
        end
        rst = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_chk++;
            if ({seg, an, upd} !== {e_seg, e_an, e_upd}) begin
                n_fail++;
                $display("FAIL mid_model t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg, an, upd, e_seg, e_an, e_upd);
            end
            if (i < 4 || i == 8) begin
                n_chk++;
                if ((i < 4 && {an, seg} !== {2'b01, 7'h7E}) ||
                    (i == 8 && {an, seg} !== {2'b01, 7'h6D})) begin
                    n_fail++;
                    $display("FAIL mid_after i=%0d an=%b seg=%h", i, an, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            count = 4'($urandom_range(0, 15));
            en    = ($urandom_range(0, 9) != 0);
            rst   = ($urandom_range(0, 49) != 0);
            tick();
            n_chk++;
            if ({seg, an, upd} !== {e_seg, e_an, e_upd}) begin
                n_fail++;
                $display("FAIL rand_model i=%0d got %h/%b/%b want %h/%b/%b",
                         i, seg, an, upd, e_seg, e_an, e_upd);
            end
        end
        rst = 1;
        en  = 1;
    endtask

    initial begin
        clk    = 0;
        rst    = 0;
        count  = 4'd0;
        en     = 1;
        n_chk  = 0;
        n_fail = 0;
        t      = 0;
        m_cnt  = 0;
        m_disp = 0;
        e_seg  = 7'h00;
        e_an   = 2'b00;
        e_upd  = 1'b0;
        test_reset();
        test_hold13();
        test_no_tear();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count4_disp2.md
Name: count4_disp2

Overview:
- Display stage directly downstream of the 4-bit up/down counter; consumes its 4-bit count (0..15).
- Drives a two-digit, time-multiplexed 7-segment display showing the count in decimal ("0".."15").
- Tens digit is blanked when the value is below 10.
- The displayed value updates only at frame boundaries, so a digit never shows a torn value.

Parameters:
- REFRESH_DIV, 4: clock cycles each digit is driven before switching; legal range >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- count  in  4  unsigned value from the up/down counter.
- en  in  1  display enable; 0 blanks the outputs without stopping internal timing.
- seg  out  7  segment drive {a,b,c,d,e,f,g}, with seg[6]=a; active-high.
- an  out  2  digit select, one-hot, active-high; an[0]=units, an[1]=tens.
- upd  out  1  one-cycle pulse when a new, different value is latched for display.

Behaviour:
- Reset (rst=0 at a clock edge) clears all state on that edge:
  - div_q=0, sel_q=0 (units phase), cnt_q=0, disp_q=0.
  - Outputs: seg=7'h00, an=2'b00, upd=0.
  - Reset applies identically mid-frame or mid-phase; the next frame starts in the units phase with div_q=0.
- Input capture: cnt_q <= count on every edge (one register stage, no filtering).
- Refresh timing:
  - div_q counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1, div_q wraps to 0 and sel_q toggles.
  - Each phase lasts REFRESH_DIV cycles; a frame (units then tens) lasts 2*REFRESH_DIV cycles.
  - REFRESH_DIV=1 toggles sel_q every cycle.
- Frame latch:
  - On the edge where div_q==REFRESH_DIV-1 and sel_q==1 (end of the tens phase): disp_q <= cnt_q, and upd <= (cnt_q != disp_q).
  - upd=0 on all other edges.
  - Count changes during a frame are ignored until the next frame boundary. Intermediate values that revert before the boundary are never displayed.
- Digit split of disp_q:
  - tens = (disp_q >= 10) ? 1 : blank.
  - units = (disp_q >= 10) ? disp_q-10 : disp_q.
- Segment codes:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - blank=00.
- Output register, updated every edge from current sel_q/disp_q:
  - an <= en ? (sel_q ? 2'b10 : 2'b01) : 2'b00.
  - seg <= en ? code(sel_q ? tens : units) : 7'h00.
  - A blanked tens digit still asserts an[1] while seg=00.
  - an and seg lag sel_q by one cycle; they are always mutually consistent.
- Latency: a count change is shown, worst case, 1 + 2*REFRESH_DIV + 1 cycles later.
- en affects only the an/seg drive:
  - div_q, sel_q, disp_q and upd keep running while en=0.
  - Re-enabling resumes in the current phase with no resynchronisation.
- Wrap-around: 15->0 and 0->15 transitions from the counter need no special handling; each frame shows whatever value is latched.
- No combinational path from any input to any output.

Test Plan (REFRESH_DIV=4):
1. Reset: hold rst=0 for 3 edges, count=5, en=1.
   - During reset: seg=00, an=00, upd=0.
   - After release: first units phase an=01, seg=7E ("0"); tens phase an=10, seg=00.
   - At the first frame boundary (8 cycles after release): upd pulses once; next units phase seg=5B.
2. count=13 held from reset release.
   - After the first latch: units phase an=01, seg=79; tens phase an=10, seg=30.
   - Each phase lasts exactly 4 cycles.
   - upd pulses once only; subsequent frames give upd=0.
3. No tearing: displaying 7; change count to 8 during the units phase.
   - Units seg stays 70 through the rest of that frame.
   - seg=7F appears in the first units phase after the tens-phase boundary.
   - Separately, pulse count 3->4->3 within one frame: no upd pulse and no change in seg.
4. Wrap-around: count steps 14, 15, 0, one step per frame.
   - Units seg sequence 33, 5B, 7E.
   - Tens seg 30, 30, 00.
   - upd pulses once at each boundary.
5. Enable: en=0 for 6 cycles mid-frame.
   - an=00 and seg=00 from the next edge.
   - Phase timing is unchanged on re-enable: an resumes with the same sel sequence as an uninterrupted run.
6. Reset mid-frame: assert rst=0 in the 2nd cycle of the tens phase while displaying 12.
   - Next edge: an=00, seg=00, disp_q=0.
   - After release: units phase first, showing "0" until the next frame boundary.
